// File: rtl/pong_ctrl.sv
// pong_ctrl: game sequencer for the pong datapath. Owns ball position and
// direction, paddle position, lives and the IDLE/PLAY/WAIT/OVER state machine.
// All motion advances once per frame on refr_tick.
module pong_ctrl #(
    parameter int BALL_SIZE = 8,
    parameter int BALL_V    = 2,
    parameter int PAD_H     = 72,
    parameter int PAD_V     = 4,
    parameter int LIVES     = 3,
    parameter int WAIT_FR   = 60
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       refr_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_start,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [9:0] paddle_y,
    output logic       ball_on_en,
    output logic       hit,
    output logic       miss,
    output logic [1:0] lives,
    output logic       game_over
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_OVER = 2'd3;

    localparam logic [9:0] SERVE_X  = 10'd320;
    localparam logic [9:0] SERVE_Y  = 10'd236;
    localparam logic [9:0] PAD_Y0   = 10'd204;
    localparam logic [9:0] WALL_X   = 10'd36;
    localparam logic [9:0] PAD_L    = 10'd600;
    localparam logic [9:0] PAD_R    = 10'd603;
    localparam logic [9:0] MISS_X   = 10'd632;
    localparam logic [9:0] BS       = 10'(BALL_SIZE);
    localparam logic [9:0] BV       = 10'(BALL_V);
    localparam logic [9:0] PH       = 10'(PAD_H);
    localparam logic [9:0] PV       = 10'(PAD_V);
    localparam logic [9:0] BOT_LIM  = 10'(480 - BALL_V);
    localparam logic [9:0] PAD_MAX  = 10'(480 - PAD_H);
    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam int         FC_W     = $clog2(WAIT_FR + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(WAIT_FR - 1);

    logic [1:0]      state;
    logic            dx_pos;
    logic            dy_pos;
    logic [FC_W-1:0] frame_cnt;

    logic [9:0] pad_next;
    logic       dx_next;
    logic       dy_next;
    logic [9:0] bx_next;
    logic [9:0] by_next;
    logic       pad_hit;
    logic       ball_miss;

    // Paddle candidate position for this frame, clamped to the screen.
    always_comb begin
        pad_next = paddle_y;
        if (btn_up && !btn_down) begin
            pad_next = (paddle_y < PV) ? 10'd0 : paddle_y - PV;
        end else if (btn_down && !btn_up) begin
            pad_next = (paddle_y + PV > PAD_MAX) ? PAD_MAX : paddle_y + PV;
        end
    end

    // Ball bounce decisions on the current position, then the stepped position.
    always_comb begin
        ball_miss = (ball_x >= MISS_X);
        pad_hit   = dx_pos
                    && (ball_x + BS - 10'd1 >= PAD_L)
                    && (ball_x + BS - 10'd1 <= PAD_R)
                    && (ball_y + BS - 10'd1 >= paddle_y)
                    && (ball_y <= paddle_y + PH - 10'd1);

        dy_next = dy_pos;
        if (ball_y <= BV) begin
            dy_next = 1'b1;
        end else if (ball_y + BS >= BOT_LIM) begin
            dy_next = 1'b0;
        end

        dx_next = dx_pos;
        if (ball_x <= WALL_X) begin
            dx_next = 1'b1;
        end else if (pad_hit) begin
            dx_next = 1'b0;
        end

        bx_next = dx_next ? ball_x + BV : ball_x - BV;
        by_next = dy_next ? ball_y + BV : ball_y - BV;
    end

    // Game state machine and all registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            ball_x     <= SERVE_X;
            ball_y     <= SERVE_Y;
            paddle_y   <= PAD_Y0;
            dx_pos     <= 1'b1;
            dy_pos     <= 1'b1;
            ball_on_en <= 1'b1;
            lives      <= LIVES_INIT;
            hit        <= 1'b0;
            miss       <= 1'b0;
            game_over  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (btn_start) begin
                        state <= S_PLAY;
                    end else if (refr_tick) begin
                        paddle_y <= pad_next;
                    end
                end
                S_PLAY: begin
                    if (refr_tick) begin
                        paddle_y <= pad_next;
                        if (ball_miss) begin
                            miss       <= 1'b1;
                            lives      <= lives - 2'd1;
                            ball_on_en <= 1'b0;
                            if (lives == 2'd1) begin
                                state     <= S_OVER;
                                game_over <= 1'b1;
                            end else begin
                                state     <= S_WAIT;
                                frame_cnt <= '0;
                            end
                        end else begin
                            dx_pos <= dx_next;
                            dy_pos <= dy_next;
                            ball_x <= bx_next;
                            ball_y <= by_next;
                            hit    <= pad_hit;
                        end
                    end
                end
                S_WAIT: begin
                    if (refr_tick) begin
                        paddle_y <= pad_next;
                        if (frame_cnt == FC_LAST) begin
                            frame_cnt  <= '0;
                            ball_x     <= SERVE_X;
                            ball_y     <= SERVE_Y;
                            dx_pos     <= 1'b1;
                            dy_pos     <= 1'b1;
                            ball_on_en <= 1'b1;
                            state      <= S_PLAY;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_OVER: begin
                    if (btn_start) begin
                        lives      <= LIVES_INIT;
                        ball_x     <= SERVE_X;
                        ball_y     <= SERVE_Y;
                        dx_pos     <= 1'b1;
                        dy_pos     <= 1'b1;
                        ball_on_en <= 1'b1;
                        game_over  <= 1'b0;
                        state      <= S_PLAY;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pong_ctrl.sv
// tb_pong_ctrl: self-checking bench for pong_ctrl. A frame-level reference
// model predicts every output after each clock; predictions go through a queue
// and a monitor compares them against the DUT, while each scenario task also
// checks its own fixed landmark values.
module tb_pong_ctrl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       refr_tick = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       btn_start = 1'b0;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_y;
    logic       ball_on_en;
    logic       hit;
    logic       miss;
    logic [1:0] lives;
    logic       game_over;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] py;
        logic       on;
        logic       hit;
        logic       miss;
        logic [1:0] lives;
        logic       over;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state (0 idle, 1 play, 2 wait, 3 over).
    int m_state, m_bx, m_by, m_py, m_dx, m_dy, m_on, m_hit, m_miss, m_lives, m_over, m_fc;

    pong_ctrl dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .refr_tick  (refr_tick),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .btn_start  (btn_start),
        .ball_x     (ball_x),
        .ball_y     (ball_y),
        .paddle_y   (paddle_y),
        .ball_on_en (ball_on_en),
        .hit        (hit),
        .miss       (miss),
        .lives      (lives),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    task automatic model_serve();
        m_bx = 320; m_by = 236; m_dx = 2; m_dy = 2; m_on = 1;
    endtask

    task automatic model_reset();
        m_state = 0; m_py = 204; m_lives = 3; m_hit = 0; m_miss = 0;
        m_over = 0; m_fc = 0;
        model_serve();
    endtask

    task automatic model_step(input bit tick, input bit up, input bit down, input bit start);
        int np;
        m_hit = 0;
        m_miss = 0;
        np = m_py;
        if (up && !down) np = (m_py < 4) ? 0 : m_py - 4;
        else if (down && !up) np = (m_py + 4 > 408) ? 408 : m_py + 4;
        case (m_state)
            0: begin
                if (start) m_state = 1;
                else if (tick) m_py = np;
            end
            1: begin
                if (tick) begin
                    if (m_bx >= 632) begin
                        m_miss = 1;
                        m_lives = m_lives - 1;
                        m_on = 0;
                        if (m_lives == 0) begin
                            m_state = 3; m_over = 1;
                        end else begin
                            m_state = 2; m_fc = 0;
                        end
                    end else begin
                        if (m_by <= 2) m_dy = 2;
                        else if (m_by + 8 >= 478) m_dy = -2;
                        if (m_bx <= 36) m_dx = 2;
                        else if (m_dx > 0 && m_bx + 7 >= 600 && m_bx + 7 <= 603 &&
                                 m_by + 7 >= m_py && m_by <= m_py + 71) begin
                            m_dx = -2;
                            m_hit = 1;
                        end
                        m_bx = m_bx + m_dx;
                        m_by = m_by + m_dy;
                    end
                    m_py = np;
                end
            end
            2: begin
                if (tick) begin
                    m_py = np;
                    m_fc = m_fc + 1;
                    if (m_fc == 60) begin
                        m_fc = 0;
                        model_serve();
                        m_state = 1;
                    end
                end
            end
            default: begin
                if (start) begin
                    m_lives = 3;
                    model_serve();
                    m_over = 0;
                    m_state = 1;
                end
            end
        endcase
    endtask

    // Drive one clock of stimulus, push the model's prediction, wait past the edge.
    task automatic step(input bit rst, input bit tick, input bit up, input bit down, input bit start);
        exp_t e;
        @(negedge clk);
        reset_n   = !rst;
        refr_tick = tick;
        btn_up    = up;
        btn_down  = down;
        btn_start = start;
        if (rst) model_reset();
        else model_step(tick, up, down, start);
        e.bx = 10'(m_bx); e.by = 10'(m_by); e.py = 10'(m_py);
        e.on = 1'(m_on); e.hit = 1'(m_hit); e.miss = 1'(m_miss);
        e.lives = 2'(m_lives); e.over = 1'(m_over);
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        refr_tick = 1'b0;
        btn_start = 1'b0;
    endtask

    // One frame: the tick cycle followed by a quiet cycle so pulses must drop.
    task automatic frame(input bit up, input bit down, input bit start);
        step(1'b0, 1'b1, up, down, start);
        step(1'b0, 1'b0, up, down, 1'b0);
    endtask

    // Scoreboard monitor: pop one prediction per clock and compare with the DUT.
    always begin
        exp_t e;
        exp_t got;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            got = {ball_x, ball_y, paddle_y, ball_on_en, hit, miss, lives, game_over};
            checks++;
            if (got !== e) begin
                errors++;
                $display("[TB] FAIL scoreboard t=%0t got bx=%0d by=%0d py=%0d on=%0b hit=%0b miss=%0b lives=%0d over=%0b expected bx=%0d by=%0d py=%0d on=%0b hit=%0b miss=%0b lives=%0d over=%0b",
                         $time, got.bx, got.by, got.py, got.on, got.hit, got.miss, got.lives, got.over,
                         e.bx, e.by, e.py, e.on, e.hit, e.miss, e.lives, e.over);
            end
        end
    end

    task automatic test_reset();
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y, paddle_y, lives, game_over, ball_on_en, hit, miss} !==
            {10'd320, 10'd236, 10'd204, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values got bx=%0d by=%0d py=%0d lives=%0d over=%0b on=%0b expected 320 236 204 3 0 1",
                     ball_x, ball_y, paddle_y, lives, game_over, ball_on_en);
        end
    endtask

    task automatic test_idle();
        repeat (5) frame(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y, paddle_y} !== {10'd320, 10'd236, 10'd204}) begin
            errors++;
            $display("[TB] FAIL idle_parked got bx=%0d by=%0d py=%0d expected 320 236 204", ball_x, ball_y, paddle_y);
        end
    endtask

    task automatic test_paddle_up();
        for (int i = 1; i <= 60; i++) begin
            frame(1'b1, 1'b0, 1'b0);
            if (i == 50 || i == 51 || i == 60) begin
                checks++;
                if (paddle_y !== ((i == 50) ? 10'd4 : 10'd0)) begin
                    errors++;
                    $display("[TB] FAIL paddle_up_clamp tick=%0d got %0d expected %0d", i, paddle_y, (i == 50) ? 4 : 0);
                end
            end
        end
    endtask

    task automatic test_paddle_down();
        for (int i = 1; i <= 110; i++) begin
            frame(1'b0, 1'b1, 1'b0);
            if (i == 101 || i == 102 || i == 110) begin
                checks++;
                if (paddle_y !== ((i == 101) ? 10'd404 : 10'd408)) begin
                    errors++;
                    $display("[TB] FAIL paddle_down_clamp tick=%0d got %0d expected %0d", i, paddle_y, (i == 101) ? 404 : 408);
                end
            end
        end
        repeat (3) frame(1'b1, 1'b0, 1'b0);
        repeat (5) frame(1'b1, 1'b1, 1'b0);
        checks++;
        if (paddle_y !== 10'd396) begin
            errors++;
            $display("[TB] FAIL paddle_both_hold got %0d expected 396", paddle_y);
        end
    endtask

    task automatic test_start();
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checks++;
        if ({ball_x, ball_y, paddle_y} !== {10'd320, 10'd236, 10'd396}) begin
            errors++;
            $display("[TB] FAIL start_no_motion got bx=%0d by=%0d py=%0d expected 320 236 396", ball_x, ball_y, paddle_y);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y} !== {10'd322, 10'd238}) begin
            errors++;
            $display("[TB] FAIL play_first_move got bx=%0d by=%0d expected 322 238", ball_x, ball_y);
        end
    endtask

    // Paddle follows the ball for a long rally covering a hit, a top and a left bounce.
    task automatic test_rally();
        bit hit_seen = 0, top_seen = 0, wall_seen = 0;
        int prev_bx, prev_by;
        bit up, down;
        prev_bx = ball_x;
        prev_by = ball_y;
        for (int i = 0; i < 450; i++) begin
            up   = (m_py + 36 > m_by + 4 + 4);
            down = (m_py + 36 + 4 < m_by + 4);
            step(1'b0, 1'b1, up, down, 1'b0);
            if (hit === 1'b1) begin
                hit_seen = 1;
                checks++;
                if (ball_x !== 10'd592) begin
                    errors++;
                    $display("[TB] FAIL hit_position got bx=%0d expected 592", ball_x);
                end
            end
            if (prev_by == 2 && ball_y == 10'd4) top_seen = 1;
            if (prev_bx == 36 && ball_x == 10'd38) wall_seen = 1;
            prev_bx = ball_x;
            prev_by = ball_y;
            step(1'b0, 1'b0, up, down, 1'b0);
        end
        checks++;
        if ({hit_seen, top_seen, wall_seen, lives} !== {3'b111, 2'd3}) begin
            errors++;
            $display("[TB] FAIL rally_events got hit=%0b top=%0b wall=%0b lives=%0d expected 1 1 1 3",
                     hit_seen, top_seen, wall_seen, lives);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y, paddle_y, lives, ball_on_en} !== {10'd320, 10'd236, 10'd204, 2'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_mid_game got bx=%0d by=%0d py=%0d lives=%0d on=%0b expected 320 236 204 3 1",
                     ball_x, ball_y, paddle_y, lives, ball_on_en);
        end
        frame(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y} !== {10'd320, 10'd236}) begin
            errors++;
            $display("[TB] FAIL reset_to_idle got bx=%0d by=%0d expected 320 236", ball_x, ball_y);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Paddle parked at the top; the serve trajectory passes below it and misses.
    task automatic test_miss();
        int n = 0;
        bit found = 0;
        while (!found && n < 400) begin
            n++;
            step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            if (miss === 1'b1) found = 1;
            step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (!found || n != 157 || lives !== 2'd2 || ball_on_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL miss_event got found=%0b frame=%0d lives=%0d on=%0b expected 1 157 2 0",
                     found, n, lives, ball_on_en);
        end
        repeat (59) frame(1'b1, 1'b0, 1'b0);
        checks++;
        if (ball_on_en !== 1'b0) begin
            errors++;
            $display("[TB] FAIL wait_blank got on=%0b expected 0", ball_on_en);
        end
        frame(1'b1, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y, ball_on_en} !== {10'd320, 10'd236, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reserve got bx=%0d by=%0d on=%0b expected 320 236 1", ball_x, ball_y, ball_on_en);
        end
        frame(1'b1, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y} !== {10'd322, 10'd238}) begin
            errors++;
            $display("[TB] FAIL replay_move got bx=%0d by=%0d expected 322 238", ball_x, ball_y);
        end
    endtask

    task automatic test_game_over();
        int n = 0;
        while (game_over !== 1'b1 && n < 1000) begin
            n++;
            frame(1'b1, 1'b0, 1'b0);
        end
        checks++;
        if ({game_over, lives, ball_on_en} !== {1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL game_over got over=%0b lives=%0d on=%0b after %0d frames expected 1 0 0",
                     game_over, lives, ball_on_en, n);
        end
        repeat (10) frame(1'b0, 1'b1, 1'b0);
        checks++;
        if (paddle_y !== 10'd0) begin
            errors++;
            $display("[TB] FAIL over_paddle_frozen got %0d expected 0", paddle_y);
        end
        step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checks++;
        if ({lives, game_over, ball_on_en, ball_x, ball_y, paddle_y} !==
            {2'd3, 1'b0, 1'b1, 10'd320, 10'd236, 10'd0}) begin
            errors++;
            $display("[TB] FAIL restart_same_tick got lives=%0d over=%0b on=%0b bx=%0d by=%0d py=%0d expected 3 0 1 320 236 0",
                     lives, game_over, ball_on_en, ball_x, ball_y, paddle_y);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        frame(1'b0, 1'b0, 1'b0);
        checks++;
        if ({ball_x, ball_y} !== {10'd322, 10'd238}) begin
            errors++;
            $display("[TB] FAIL restart_move got bx=%0d by=%0d expected 322 238", ball_x, ball_y);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_paddle_up();
        test_paddle_down();
        test_start();
        test_rally();
        test_reset_mid();
        test_miss();
        test_game_over();
        @(posedge clk);
        #2;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "[TB] timeout");
    end

endmodule
